// File: rtl/control_fsm_if.sv
// Control bus between the control FSM and the rest of the 8-bit processor.
// master: the control unit. It takes the opcode and the memory handshake, and drives the
//         datapath controls.
// slave : the instruction memory, data memory and datapath side.
// Signals: OPCODE, INSTR_VALID, BUSYWAIT (into the control unit); WRITEENABLE, ALUSRC,
//          ALUOP, NEMUX, BRANCH, BRANCH_NE, JUMP, MEMREAD, MEMWRITE, WBSEL, PC_STALL,
//          ERR (out of the control unit).
interface control_fsm_if #(
  parameter int unsigned OPCODE_W = 8,
  parameter int unsigned ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] OPCODE;
  logic                INSTR_VALID;
  logic                BUSYWAIT;
  logic                WRITEENABLE;
  logic                ALUSRC;
  logic [ALUOP_W-1:0]  ALUOP;
  logic                NEMUX;
  logic                BRANCH;
  logic                BRANCH_NE;
  logic                JUMP;
  logic                MEMREAD;
  logic                MEMWRITE;
  logic                WBSEL;
  logic                PC_STALL;
  logic [1:0]          ERR;

  modport master (
    input  OPCODE, INSTR_VALID, BUSYWAIT,
    output WRITEENABLE, ALUSRC, ALUOP, NEMUX, BRANCH, BRANCH_NE, JUMP,
           MEMREAD, MEMWRITE, WBSEL, PC_STALL, ERR
  );

  modport slave (
    output OPCODE, INSTR_VALID, BUSYWAIT,
    input  WRITEENABLE, ALUSRC, ALUOP, NEMUX, BRANCH, BRANCH_NE, JUMP,
           MEMREAD, MEMWRITE, WBSEL, PC_STALL, ERR
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 8-bit processor.
// It decodes the opcode and sequences the data-memory busy-wait handshakes and the
// multi-cycle multiply. It stalls the PC while a multi-cycle operation runs, and traps on
// an illegal opcode or a memory timeout.
// Ports:
//   CLK   - rising-edge clock.
//   RESET - asynchronous active-high reset.
//   bus   - control_fsm_if.master: opcode and handshake in, registered controls out.
module control_fsm #(
  parameter int unsigned OPCODE_W    = 8,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MULT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic           CLK,
  input logic           RESET,
  control_fsm_if.master bus
);
  localparam int unsigned MultW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [MultW-1:0] MultInit = MultW'(MULT_CYCLES - 1);
  localparam logic [WaitW-1:0] TimeoutV = WaitW'(MEM_TIMEOUT);

  localparam logic [ALUOP_W-1:0] AluFwd = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluMul = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AluSll = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] AluSrl = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] AluSra = ALUOP_W'(7);

  typedef enum logic [2:0] {StDecode, StMem, StWb, StMult, StTrap} state_e;

  typedef struct packed {
    logic               we;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               nemux;
    logic               branch;
    logic               branch_ne;
    logic               jump;
    logic               memread;
    logic               memwrite;
    logic               wbsel;
    logic               pc_stall;
  } outs_t;

  state_e           state_q, state_d;
  outs_t            out_q, out_d;
  logic [1:0]       err_q, err_d;
  logic [MultW-1:0] mcnt_q, mcnt_d;
  logic [WaitW-1:0] wcnt_q, wcnt_d;
  logic [WaitW-1:0] wait_inc;
  logic [31:0]      opc_ext;

  assign opc_ext = 32'(bus.OPCODE);

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    err_d    = err_q;
    mcnt_d   = mcnt_q;
    wcnt_d   = wcnt_q;
    wait_inc = wcnt_q + WaitW'(1);

    unique case (state_q)
      StDecode: begin
        out_d = '0;
        if (!bus.INSTR_VALID) begin
          out_d.pc_stall = 1'b1;
        end else begin
          wcnt_d = '0;
          case (opc_ext)
            32'd0:  begin out_d.we = 1'b1; out_d.alusrc = 1'b1; out_d.aluop = AluAdd; end
            32'd1:  begin
              out_d.we = 1'b1; out_d.alusrc = 1'b1; out_d.aluop = AluAdd; out_d.nemux = 1'b1;
            end
            32'd2:  begin out_d.we = 1'b1; out_d.alusrc = 1'b1; out_d.aluop = AluAnd; end
            32'd3:  begin out_d.we = 1'b1; out_d.alusrc = 1'b1; out_d.aluop = AluOr; end
            32'd4:  begin out_d.we = 1'b1; out_d.alusrc = 1'b1; out_d.aluop = AluFwd; end
            32'd5:  out_d.we = 1'b1;
            32'd6:  out_d.jump = 1'b1;
            32'd7:  begin
              out_d.alusrc = 1'b1; out_d.aluop = AluAdd; out_d.nemux = 1'b1;
              out_d.branch = 1'b1;
            end
            32'd8:  begin
              out_d.alusrc = 1'b1; out_d.aluop = AluAdd; out_d.nemux = 1'b1;
              out_d.branch_ne = 1'b1;
            end
            32'd9, 32'd10: begin
              out_d.alusrc   = (opc_ext == 32'd9);
              out_d.memread  = 1'b1;
              out_d.pc_stall = 1'b1;
              state_d        = StMem;
            end
            32'd11, 32'd12: begin
              out_d.alusrc   = (opc_ext == 32'd11);
              out_d.memwrite = 1'b1;
              out_d.pc_stall = 1'b1;
              state_d        = StMem;
            end
            32'd13: begin
              out_d.alusrc = 1'b1;
              out_d.aluop  = AluMul;
              if (MULT_CYCLES > 1) begin
                out_d.pc_stall = 1'b1;
                mcnt_d         = MultInit;
                state_d        = StMult;
              end else begin
                out_d.we = 1'b1;
              end
            end
            32'd14: begin out_d.we = 1'b1; out_d.aluop = AluSll; end
            32'd15: begin out_d.we = 1'b1; out_d.aluop = AluSrl; end
            32'd16: begin out_d.we = 1'b1; out_d.aluop = AluSra; end
            default: begin
              out_d.pc_stall = 1'b1;
              err_d          = 2'b01;
              state_d        = StTrap;
            end
          endcase
        end
      end

      StMem: begin
        if (bus.BUSYWAIT) begin
          wcnt_d = wait_inc;
          if ((MEM_TIMEOUT != 0) && (wait_inc == TimeoutV)) begin
            out_d          = '0;
            out_d.pc_stall = 1'b1;
            err_d          = 2'b10;
            state_d        = StTrap;
          end
        end else if (out_q.memread) begin
          // Load completes: one write-back cycle with the PC still held.
          out_d          = '0;
          out_d.we       = 1'b1;
          out_d.wbsel    = 1'b1;
          out_d.pc_stall = 1'b1;
          state_d        = StWb;
        end else begin
          out_d   = '0;
          state_d = StDecode;
        end
      end

      StWb: begin
        out_d   = '0;
        state_d = StDecode;
      end

      StMult: begin
        if (mcnt_q == '0) begin
          out_d   = '0;
          state_d = StDecode;
        end else begin
          mcnt_d = mcnt_q - MultW'(1);
          // The last execute cycle writes the product and releases the PC.
          if (mcnt_q == MultW'(1)) begin
            out_d.we       = 1'b1;
            out_d.pc_stall = 1'b0;
          end
        end
      end

      StTrap: ;

      default: begin
        out_d   = '0;
        state_d = StDecode;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StDecode;
      out_q   <= '0;
      err_q   <= '0;
      mcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
      mcnt_q  <= mcnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.WRITEENABLE = out_q.we;
  assign bus.ALUSRC      = out_q.alusrc;
  assign bus.ALUOP       = out_q.aluop;
  assign bus.NEMUX       = out_q.nemux;
  assign bus.BRANCH      = out_q.branch;
  assign bus.BRANCH_NE   = out_q.branch_ne;
  assign bus.JUMP        = out_q.jump;
  assign bus.MEMREAD     = out_q.memread;
  assign bus.MEMWRITE    = out_q.memwrite;
  assign bus.WBSEL       = out_q.wbsel;
  assign bus.PC_STALL    = out_q.pc_stall;
  assign bus.ERR         = err_q;
endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm.
// u_dut0: MULT_CYCLES=3, MEM_TIMEOUT=4.
// u_dut1: MULT_CYCLES=1, MEM_TIMEOUT=0 (timeout disabled). It shares the inputs of u_dut0.
module tb_control_fsm;
  localparam int MC0 = 3;
  localparam int T0  = 4;

  typedef struct packed {
    logic       we;
    logic       alusrc;
    logic [2:0] aluop;
    logic       nemux;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       memread;
    logic       memwrite;
    logic       wbsel;
    logic       pc_stall;
    logic [1:0] err;
  } obs_t;

  typedef struct packed {
    logic       v;
    logic [7:0] op;
    logic       bw;
    obs_t       e;
    obs_t       m;
  } step_t;

  logic  clk;
  logic  rst;
  int    checks;
  int    errors;
  step_t q[$];
  obs_t  full_m;
  obs_t  idle_m;

  control_fsm_if #(.OPCODE_W(8), .ALUOP_W(3)) if0 ();
  control_fsm_if #(.OPCODE_W(8), .ALUOP_W(3)) if1 ();

  assign if1.OPCODE      = if0.OPCODE;
  assign if1.INSTR_VALID = if0.INSTR_VALID;
  assign if1.BUSYWAIT    = if0.BUSYWAIT;

  control_fsm #(.OPCODE_W(8), .ALUOP_W(3), .MULT_CYCLES(3), .MEM_TIMEOUT(4)) u_dut0 (
    .CLK  (clk),
    .RESET(rst),
    .bus  (if0)
  );

  control_fsm #(.OPCODE_W(8), .ALUOP_W(3), .MULT_CYCLES(1), .MEM_TIMEOUT(0)) u_dut1 (
    .CLK  (clk),
    .RESET(rst),
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample0();
    obs_t o;
    o.we = if0.WRITEENABLE; o.alusrc = if0.ALUSRC; o.aluop = if0.ALUOP;
    o.nemux = if0.NEMUX; o.branch = if0.BRANCH; o.branch_ne = if0.BRANCH_NE;
    o.jump = if0.JUMP; o.memread = if0.MEMREAD; o.memwrite = if0.MEMWRITE;
    o.wbsel = if0.WBSEL; o.pc_stall = if0.PC_STALL; o.err = if0.ERR;
    return o;
  endfunction

  function automatic obs_t sample1();
    obs_t o;
    o.we = if1.WRITEENABLE; o.alusrc = if1.ALUSRC; o.aluop = if1.ALUOP;
    o.nemux = if1.NEMUX; o.branch = if1.BRANCH; o.branch_ne = if1.BRANCH_NE;
    o.jump = if1.JUMP; o.memread = if1.MEMREAD; o.memwrite = if1.MEMWRITE;
    o.wbsel = if1.WBSEL; o.pc_stall = if1.PC_STALL; o.err = if1.ERR;
    return o;
  endfunction

  // Outputs right after the latching edge, straight from the decode table (u_dut0 config).
  function automatic obs_t dec(int op);
    obs_t e;
    e = '0;
    case (op)
      0:  begin e.we = 1; e.alusrc = 1; e.aluop = 3'b001; end
      1:  begin e.we = 1; e.alusrc = 1; e.aluop = 3'b001; e.nemux = 1; end
      2:  begin e.we = 1; e.alusrc = 1; e.aluop = 3'b010; end
      3:  begin e.we = 1; e.alusrc = 1; e.aluop = 3'b011; end
      4:  begin e.we = 1; e.alusrc = 1; end
      5:  e.we = 1;
      6:  e.jump = 1;
      7:  begin e.alusrc = 1; e.aluop = 3'b001; e.nemux = 1; e.branch = 1; end
      8:  begin e.alusrc = 1; e.aluop = 3'b001; e.nemux = 1; e.branch_ne = 1; end
      9:  begin e.alusrc = 1; e.memread = 1; e.pc_stall = 1; end
      10: begin e.memread = 1; e.pc_stall = 1; end
      11: begin e.alusrc = 1; e.memwrite = 1; e.pc_stall = 1; end
      12: begin e.memwrite = 1; e.pc_stall = 1; end
      13: begin e.alusrc = 1; e.aluop = 3'b100; e.pc_stall = 1; end
      14: begin e.we = 1; e.aluop = 3'b101; end
      15: begin e.we = 1; e.aluop = 3'b110; end
      16: begin e.we = 1; e.aluop = 3'b111; end
      default: begin e.pc_stall = 1; e.err = 2'b01; end
    endcase
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] rop();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic push(logic v, logic [7:0] op, logic bw, obs_t e, obs_t m);
    step_t s;
    s.v = v; s.op = op; s.bw = bw; s.e = e; s.m = m;
    q.push_back(s);
  endtask

  task automatic push_idle();
    obs_t e;
    e = '0;
    e.pc_stall = 1;
    push(1'b0, rop(), rb(), e, idle_m);
  endtask

  // Edge-by-edge expectation of one instruction on u_dut0 followed by b busy cycles.
  // Only the latching edge carries a valid opcode; later edges feed random, ignored inputs.
  task automatic build_instr(int op, int b);
    obs_t e, z, t;
    int   nb;
    e = dec(op);
    z = '0;
    if (op >= 17) begin
      push(1'b1, 8'(op), rb(), e, full_m);
    end else if (op >= 9 && op <= 12) begin
      push(1'b1, 8'(op), rb(), e, full_m);
      nb = (b >= T0) ? T0 - 1 : b;
      for (int i = 0; i < nb; i++) push(rb(), rop(), 1'b1, e, full_m);
      if (b >= T0) begin
        t = '0; t.pc_stall = 1; t.err = 2'b10;
        push(rb(), rop(), 1'b1, t, full_m);
      end else if (op <= 10) begin
        t = '0; t.we = 1; t.wbsel = 1; t.pc_stall = 1;
        push(rb(), rop(), 1'b0, t, full_m);
        push(rb(), rop(), rb(), z, full_m);
      end else begin
        push(rb(), rop(), 1'b0, z, full_m);
      end
    end else if (op == 13) begin
      for (int i = 0; i < MC0; i++) begin
        t = e;
        if (i == MC0 - 1) begin t.we = 1; t.pc_stall = 0; end
        if (i == 0) push(1'b1, 8'(op), rb(), t, full_m);
        else        push(rb(), rop(), rb(), t, full_m);
      end
      push(rb(), rop(), rb(), z, full_m);
    end else begin
      push(1'b1, 8'(op), rb(), e, full_m);
    end
  endtask

  task automatic drive_pop(output obs_t e, output obs_t m);
    step_t s;
    s = q.pop_front();
    if0.INSTR_VALID = s.v;
    if0.OPCODE      = s.op;
    if0.BUSYWAIT    = s.bw;
    @(posedge clk);
    #1;
    e = s.e;
    m = s.m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if0.INSTR_VALID = 1'b0; if0.OPCODE = '0; if0.BUSYWAIT = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b0;
    if0.INSTR_VALID = 1'b0; if0.OPCODE = '0; if0.BUSYWAIT = 1'b0;
    #1 rst = 1'b1;
    #2;
    o = sample0(); checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_state0: got %b need 0", o); end
    o = sample1(); checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_state1: got %b need 0", o); end
    @(negedge clk);
    rst = 1'b0;
    if0.INSTR_VALID = 1'b1; if0.OPCODE = 8'd9; if0.BUSYWAIT = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    o = sample0(); checks++;
    if (o.memread !== 1'b1) begin errors++; $display("FAIL mem_entry: got %b need 1", o.memread); end
    rst = 1'b1;
    #1;
    o = sample0(); checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_mid_mem: got %b need 0", o); end
    @(negedge clk);
    rst = 1'b0;
    if0.INSTR_VALID = 1'b1; if0.OPCODE = 8'd0; if0.BUSYWAIT = 1'b0;
    @(posedge clk); #1;
    o = sample0(); checks++;
    if (o !== dec(0)) begin errors++; $display("FAIL add_after_reset: got %b need %b", o, dec(0)); end
  endtask

  task automatic test_alu_branch();
    obs_t o, e, m;
    int   ops[6] = '{0, 8, 7, 1, 6, 16};
    do_reset();
    foreach (ops[i]) build_instr(ops[i], 0);
    while (q.size() > 0) begin
      drive_pop(e, m); o = sample0(); checks++;
      if ((o & m) !== (e & m)) begin
        errors++; $display("FAIL alu_branch: got %b need %b", o & m, e & m);
      end
    end
  endtask

  task automatic test_load();
    obs_t o, e, m;
    int   n_rd, n_st, n_we;
    n_rd = 0; n_st = 0; n_we = 0;
    do_reset();
    build_instr(9, 3);
    while (q.size() > 0) begin
      drive_pop(e, m); o = sample0(); checks++;
      n_rd += int'(o.memread); n_st += int'(o.pc_stall); n_we += int'(o.we && o.wbsel);
      if ((o & m) !== (e & m)) begin
        errors++; $display("FAIL load_seq: got %b need %b", o & m, e & m);
      end
    end
    checks++;
    if (n_rd != 4 || n_st != 5 || n_we != 1) begin
      errors++; $display("FAIL load_counts: got rd=%0d st=%0d wb=%0d need 4 5 1", n_rd, n_st, n_we);
    end
  endtask

  task automatic test_store();
    obs_t o, e, m;
    int   n_wr, n_we;
    n_wr = 0; n_we = 0;
    do_reset();
    build_instr(12, 0);
    while (q.size() > 0) begin
      drive_pop(e, m); o = sample0(); checks++;
      n_wr += int'(o.memwrite); n_we += int'(o.we);
      if ((o & m) !== (e & m)) begin
        errors++; $display("FAIL store_seq: got %b need %b", o & m, e & m);
      end
    end
    checks++;
    if (n_wr != 1 || n_we != 0) begin
      errors++; $display("FAIL store_counts: got wr=%0d we=%0d need 1 0", n_wr, n_we);
    end
  endtask

  task automatic test_mult();
    obs_t o, e, m;
    int   n_mul, n_we;
    n_mul = 0; n_we = 0;
    do_reset();
    build_instr(13, 0);
    while (q.size() > 0) begin
      drive_pop(e, m); o = sample0(); checks++;
      n_mul += int'(o.aluop == 3'b100); n_we += int'(o.we);
      if ((o & m) !== (e & m)) begin
        errors++; $display("FAIL mult_seq: got %b need %b", o & m, e & m);
      end
    end
    checks++;
    if (n_mul != MC0 || n_we != 1) begin
      errors++; $display("FAIL mult_counts: got mul=%0d we=%0d need %0d 1", n_mul, n_we, MC0);
    end
  endtask

  task automatic test_random();
    obs_t o, e, m;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) push_idle();
      else build_instr(int'($urandom_range(0, 16)), int'($urandom_range(0, 3)));
    end
    while (q.size() > 0) begin
      drive_pop(e, m); o = sample0(); checks++;
      if ((o & m) !== (e & m)) begin
        errors++; $display("FAIL random_seq: got %b need %b", o & m, e & m);
      end
    end
  endtask

  // Shared by the two trap tests: hold in TRAP under random inputs, then reset clears at once.
  task automatic push_trap_hold(logic [1:0] err);
    obs_t t;
    t = '0; t.pc_stall = 1; t.err = err;
    for (int i = 0; i < 5; i++) push(rb(), rop(), rb(), t, full_m);
  endtask

  task automatic test_illegal();
    obs_t o, e, m;
    int   ops[2] = '{32, 17};
    foreach (ops[k]) begin
      do_reset();
      build_instr(ops[k], 0);
      push_trap_hold(2'b01);
      while (q.size() > 0) begin
        drive_pop(e, m); o = sample0(); checks++;
        if ((o & m) !== (e & m)) begin
          errors++; $display("FAIL illegal_%0d: got %b need %b", ops[k], o & m, e & m);
        end
      end
      rst = 1'b1;
      #1;
      o = sample0(); checks++;
      if (o !== '0) begin errors++; $display("FAIL illegal_reset: got %b need 0", o); end
      rst = 1'b0;
    end
  endtask

  task automatic test_timeout();
    obs_t o, e, m;
    do_reset();
    build_instr(9, 100);
    push_trap_hold(2'b10);
    while (q.size() > 0) begin
      drive_pop(e, m); o = sample0(); checks++;
      if ((o & m) !== (e & m)) begin
        errors++; $display("FAIL timeout_seq: got %b need %b", o & m, e & m);
      end
    end
    rst = 1'b1;
    #1;
    o = sample0(); checks++;
    if (o !== '0) begin errors++; $display("FAIL timeout_reset: got %b need 0", o); end
    rst = 1'b0;
  endtask

  // u_dut1: single-cycle multiply, and a long busy-wait with the timeout disabled.
  task automatic test_dut1();
    obs_t o, e;
    do_reset();
    if0.INSTR_VALID = 1'b1; if0.OPCODE = 8'd13; if0.BUSYWAIT = 1'b0;
    @(posedge clk); #1;
    e = '0; e.we = 1; e.alusrc = 1; e.aluop = 3'b100;
    o = sample1(); checks++;
    if (o !== e) begin errors++; $display("FAIL mult1: got %b need %b", o, e); end
    if0.OPCODE = 8'd9; if0.BUSYWAIT = 1'b1;
    e = '0; e.alusrc = 1; e.memread = 1; e.pc_stall = 1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      o = sample1(); checks++;
      if (o !== e) begin errors++; $display("FAIL no_timeout[%0d]: got %b need %b", i, o, e); end
    end
    if0.BUSYWAIT = 1'b0;
    @(posedge clk); #1;
    e = '0; e.we = 1; e.wbsel = 1; e.pc_stall = 1;
    o = sample1(); checks++;
    if (o !== e) begin errors++; $display("FAIL wb1: got %b need %b", o, e); end
    if0.INSTR_VALID = 1'b0;
    @(posedge clk); #1;
    o = sample1(); checks++;
    if (o !== '0) begin errors++; $display("FAIL wb1_exit: got %b need 0", o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    full_m = '1;
    idle_m = '0;
    idle_m.we = 1; idle_m.branch = 1; idle_m.branch_ne = 1; idle_m.jump = 1;
    idle_m.memread = 1; idle_m.memwrite = 1; idle_m.pc_stall = 1; idle_m.err = 2'b11;
    test_reset();
    test_alu_branch();
    test_load();
    test_store();
    test_mult();
    test_random();
    test_illegal();
    test_timeout();
    test_dut1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multi-cycle, parametrised control unit for the 8-bit processor. It replaces the single-cycle opcode decoder. Beyond the base opcode set it decodes branch-not-equal, memory load/store (direct and immediate), multiply and shift instructions. It sequences data-memory busy-wait handshakes and multi-cycle multiply, stalls the PC, and traps on illegal opcodes or memory timeout. It sits between instruction memory (OPCODE) and the datapath (register file, ALU, operand muxes, data memory, PC unit).

Parameters:
OPCODE_W, 8, opcode width in bits.
ALUOP_W, 3, ALUOP width in bits (minimum 3); upper bits are zero.
MULT_CYCLES, 2, execute cycles for the multiply instruction (minimum 1).
MEM_TIMEOUT, 255, maximum consecutive BUSYWAIT-high cycles in MEM; 0 disables the timeout.

Ports:
CLK  in  1  system clock, rising-edge.
RESET  in  1  asynchronous, active-high reset.
OPCODE  in  OPCODE_W  opcode of the current instruction.
INSTR_VALID  in  1  instruction memory has a stable opcode (1 = valid).
BUSYWAIT  in  1  data memory busy (1 = access in progress).
WRITEENABLE  out  1  register file write enable.
ALUSRC  out  1  ALU operand B source: 1 = register, 0 = immediate.
ALUOP  out  ALUOP_W  ALU function: 000 fwd, 001 add, 010 and, 011 or, 100 mult, 101 sll, 110 srl, 111 sra.
NEMUX  out  1  negate operand B (2's complement).
BRANCH  out  1  branch if ALU zero.
BRANCH_NE  out  1  branch if ALU not zero.
JUMP  out  1  unconditional jump.
MEMREAD  out  1  data memory read request.
MEMWRITE  out  1  data memory write request.
WBSEL  out  1  register write-data source: 1 = memory, 0 = ALU.
PC_STALL  out  1  hold the PC (1 = do not update).
ERR  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky.

Behaviour:
- Reset (asynchronous, immediate): state = DECODE; all outputs 0; internal counters 0. Reset asserted mid-MEM or mid-MULT aborts the operation at once.
- All outputs are registered. Opcode decode uses zero-extended opcode values.

State DECODE:
- At a rising edge with INSTR_VALID=1, OPCODE is latched and the outputs update for that instruction (1-cycle latency).
- INSTR_VALID=0: all strobes (WRITEENABLE, MEMREAD, MEMWRITE, BRANCH, BRANCH_NE, JUMP) go to 0, PC_STALL=1, state stays DECODE.

Decode table (WE ALUSRC ALUOP NEMUX, others 0 unless stated):
- add 0: 1 1 001 0
- sub 1: 1 1 001 1
- and 2: 1 1 010 0
- or 3: 1 1 011 0
- mov 4: 1 1 000 0
- loadi 5: 1 0 000 0
- j 6: 0 0 000 0, JUMP=1
- beq 7: 0 1 001 1, BRANCH=1
- bne 8: 0 1 001 1, BRANCH_NE=1
- lwd 9: ALUSRC=1, ALUOP=000, MEMREAD=1
- lwi 10: ALUSRC=0, ALUOP=000, MEMREAD=1
- swd 11: ALUSRC=1, ALUOP=000, MEMWRITE=1
- swi 12: ALUSRC=0, ALUOP=000, MEMWRITE=1
- mult 13: ALUSRC=1, ALUOP=100, WE=0
- sll 14, srl 15, sra 16: WE=1, ALUSRC=0, ALUOP=101/110/111
- Single-cycle opcodes (0–8, 14–16): stay in DECODE, PC_STALL=0.

Memory sequencing (opcodes 9–12):
- Latching edge: state → MEM; MEMREAD or MEMWRITE = 1; PC_STALL=1; WE=0.
- MEM: each edge with BUSYWAIT=1 increments the wait counter. The first edge with BUSYWAIT=0 clears MEMREAD/MEMWRITE.
  - Load: → WB.
  - Store: → DECODE with PC_STALL=0.
- WB: exactly one cycle with WE=1, WBSEL=1, PC_STALL=1. The next edge returns to DECODE with WE=0, WBSEL=0, PC_STALL=0.
- Load total = 2 + (busy cycles); store total = 1 + (busy cycles).
- Timeout: MEM_TIMEOUT≠0 and the wait counter reaches MEM_TIMEOUT with BUSYWAIT still 1 → TRAP, ERR=10.

Multiply sequencing (opcode 13):
- Latching edge: state → MULT; counter = MULT_CYCLES−1; PC_STALL=1; ALUOP=100 held.
- Each edge decrements the counter. In the cycle where counter=0: WE=1, PC_STALL=0. The next edge returns to DECODE.
- MULT_CYCLES=1 skips MULT entirely: a single-cycle op with WE=1.

TRAP:
- Entered by any opcode ≥17 (ERR=01) or by a memory timeout (ERR=10).
- All strobes 0, PC_STALL=1, ERR held. Exit only via RESET.

Other rules:
- OPCODE and INSTR_VALID are ignored outside DECODE.
- BUSYWAIT is ignored outside MEM.

Test Plan:
- Reset, then add (0x00) with INSTR_VALID=1 → the next edge gives WE=1, ALUSRC=1, ALUOP=001, NEMUX=0, PC_STALL=0.
- bne (0x08) → BRANCH_NE=1, BRANCH=0, NEMUX=1, ALUOP=001, WE=0. beq (0x07) → BRANCH=1, BRANCH_NE=0.
- lwd with BUSYWAIT high for 3 cycles → MEMREAD high for 4 cycles, then exactly 1 WB cycle with WE=1, WBSEL=1; PC_STALL high for 5 cycles total.
- swi with BUSYWAIT=0 throughout → MEMWRITE high for 1 cycle, WE never 1, back in DECODE after 1 cycle.
- mult with MULT_CYCLES=3 → ALUOP=100 for 3 cycles, WE=1 only in the 3rd, PC_STALL=1,1,0.
- Opcode 0x20 → ERR=01 and all strobes 0 until reset. In a separate run with MEM_TIMEOUT=4, lwd with BUSYWAIT held high → ERR=10 after 4 cycles; asserting RESET in either case clears ERR and all outputs immediately.
